// File: rtl/reg_file_rd_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_rd_pkg
// Shared constants for the operand register file: default data/address
// widths, register depth and the address of the hardwired zero entry.
// ---------------------------------------------------------------------------
package reg_file_rd_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_DEPTH  = 2 ** DEF_ADDR_W;
    localparam logic [DEF_ADDR_W-1:0] ZERO_ADDR = 5'd0;

endpackage : reg_file_rd_pkg

// File: rtl/reg_file_rd_if.sv
// ---------------------------------------------------------------------------
// reg_file_rd_if
// Bus between instruction decode / ALU operand muxes and the register file.
//   read, addr_r1, addr_r2  : read request and operand addresses
//   write, addr_w, data_w   : write port
//   data_r1, data_r2, valid : registered read results and qualifier
// master = requester (decode/ALU side), slave = register file.
// ---------------------------------------------------------------------------
interface reg_file_rd_if #(
    parameter int DATA_W = reg_file_rd_pkg::DEF_DATA_W,
    parameter int ADDR_W = reg_file_rd_pkg::DEF_ADDR_W
);
    logic              read;
    logic [ADDR_W-1:0] addr_r1;
    logic [ADDR_W-1:0] addr_r2;
    logic              write;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] data_w;
    logic [DATA_W-1:0] data_r1;
    logic [DATA_W-1:0] data_r2;
    logic              valid;

    modport master (
        output read, addr_r1, addr_r2, write, addr_w, data_w,
        input  data_r1, data_r2, valid
    );

    modport slave (
        input  read, addr_r1, addr_r2, write, addr_w, data_w,
        output data_r1, data_r2, valid
    );
endinterface : reg_file_rd_if

// File: rtl/reg_file_rd_reg32_sync.sv
// ---------------------------------------------------------------------------
// reg32_sync
// Load-enabled storage register with synchronous active-high reset.
//   clk   : clock
//   reset : synchronous clear, highest priority
//   load  : capture d on the rising edge
//   d     : data in
//   q     : stored value
// ---------------------------------------------------------------------------
module reg32_sync
    import reg_file_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_r;

    // Storage element: clear on reset, capture on load, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule : reg32_sync

// File: rtl/reg_file_rd.sv
// ---------------------------------------------------------------------------
// reg_file_rd
// Register file with one synchronous write port and two registered read
// ports (1-cycle latency, valid qualifier). Optionally entry 0 is hardwired
// to zero. A read and write of the same entry on the same edge returns the
// newly written value (write-through bypass).
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high clear of all entries and outputs
//   bus   : reg_file_rd_if slave port (read/write requests, read results)
// ---------------------------------------------------------------------------
module reg_file_rd
    import reg_file_rd_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_rd_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] entry_s [DEPTH];
    logic [DEPTH-1:0]  load_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] data_r1_r;
    logic [DATA_W-1:0] data_r2_r;
    logic              valid_r;

    // Per-entry storage; the zero entry never loads when hardwired.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (HAS_ZERO && (i == 0)) begin : g_zero
            assign load_s[i] = 1'b0;
        end else begin : g_norm
            assign load_s[i] = bus.write && (bus.addr_w == ADDR_W'(i));
        end

        reg32_sync #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (load_s[i]),
            .d     (bus.data_w),
            .q     (entry_s[i])
        );
    end

    // Read port 1 mux: zero entry first, then same-edge write bypass, then storage.
    always_comb begin
        rd1_s = entry_s[bus.addr_r1];
        if (HAS_ZERO && (bus.addr_r1 == ZADDR)) begin
            rd1_s = '0;
        end else if (bus.write && (bus.addr_w == bus.addr_r1)) begin
            rd1_s = bus.data_w;
        end else begin
            rd1_s = entry_s[bus.addr_r1];
        end
    end

    // Read port 2 mux, same priority as port 1 so equal addresses agree.
    always_comb begin
        rd2_s = entry_s[bus.addr_r2];
        if (HAS_ZERO && (bus.addr_r2 == ZADDR)) begin
            rd2_s = '0;
        end else if (bus.write && (bus.addr_w == bus.addr_r2)) begin
            rd2_s = bus.data_w;
        end else begin
            rd2_s = entry_s[bus.addr_r2];
        end
    end

    // Output registers: capture on read, hold data otherwise; valid pulses per read.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r1_r <= '0;
            data_r2_r <= '0;
            valid_r   <= 1'b0;
        end else if (bus.read) begin
            data_r1_r <= rd1_s;
            data_r2_r <= rd2_s;
            valid_r   <= 1'b1;
        end else begin
            data_r1_r <= data_r1_r;
            data_r2_r <= data_r2_r;
            valid_r   <= 1'b0;
        end
    end

    assign bus.data_r1 = data_r1_r;
    assign bus.data_r2 = data_r2_r;
    assign bus.valid   = valid_r;

endmodule : reg_file_rd

// File: tb/tb_reg_file_rd.sv
// ---------------------------------------------------------------------------
// tb_reg_file_rd
// Directed self-checking bench for reg_file_rd (ZERO_REG = 1).
// ---------------------------------------------------------------------------
module tb_reg_file_rd;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    reg_file_rd_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_rd #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.addr_r1 = 5'd0;
        bus.addr_r2 = 5'd0;
        bus.addr_w  = 5'd0;
        bus.data_w  = 32'h0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.write  = 1'b1;
        bus.read   = 1'b0;
        bus.addr_w = a;
        bus.data_w = d;
        tick();
        bus.write  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.read    = 1'b1;
        bus.addr_r1 = a1;
        bus.addr_r2 = a2;
        tick();
        bus.read    = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (bus.valid !== 1'b0) $display("FAIL reset_valid got %h want 0", bus.valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r1 !== 32'h0) $display("FAIL reset_r1 got %h want 00000000", bus.data_r1);
        else pass_cnt++;
        reset = 1'b0;
        wr(5'd5, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(5'd5, 5'd5);
        total_cnt++;
        if (bus.data_r1 !== 32'h0) $display("FAIL reset_clr_r1 got %h want 00000000", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r2 !== 32'h0) $display("FAIL reset_clr_r2 got %h want 00000000", bus.data_r2);
        else pass_cnt++;
        total_cnt++;
        if (bus.valid !== 1'b1) $display("FAIL reset_rd_valid got %h want 1", bus.valid);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        wr(5'd3, 32'hFFFFFFFF);
        wr(5'd7, 32'h12345678);
        rd(5'd3, 5'd7);
        total_cnt++;
        if (bus.data_r1 !== 32'hFFFFFFFF) $display("FAIL basic_r1 got %h want ffffffff", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r2 !== 32'h12345678) $display("FAIL basic_r2 got %h want 12345678", bus.data_r2);
        else pass_cnt++;
        total_cnt++;
        if (bus.valid !== 1'b1) $display("FAIL basic_valid got %h want 1", bus.valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.valid !== 1'b0) $display("FAIL hold_valid got %h want 0", bus.valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r1 !== 32'hFFFFFFFF) $display("FAIL hold_r1 got %h want ffffffff", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r2 !== 32'h12345678) $display("FAIL hold_r2 got %h want 12345678", bus.data_r2);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        wr(5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd0);
        total_cnt++;
        if (bus.data_r1 !== 32'h0) $display("FAIL zero_r1 got %h want 00000000", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r2 !== 32'h0) $display("FAIL zero_r2 got %h want 00000000", bus.data_r2);
        else pass_cnt++;
        total_cnt++;
        if (bus.valid !== 1'b1) $display("FAIL zero_valid got %h want 1", bus.valid);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        wr(5'd9, 32'h0000AAAA);
        bus.write   = 1'b1;
        bus.addr_w  = 5'd9;
        bus.data_w  = 32'h5555FFFF;
        bus.read    = 1'b1;
        bus.addr_r1 = 5'd9;
        bus.addr_r2 = 5'd9;
        tick();
        total_cnt++;
        if (bus.data_r1 !== 32'h5555FFFF) $display("FAIL bypass_r1 got %h want 5555ffff", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r2 !== 32'h5555FFFF) $display("FAIL bypass_r2 got %h want 5555ffff", bus.data_r2);
        else pass_cnt++;
        bus.addr_w  = 5'd0;
        bus.data_w  = 32'hCAFEF00D;
        bus.addr_r1 = 5'd0;
        bus.addr_r2 = 5'd0;
        tick();
        total_cnt++;
        if (bus.data_r1 !== 32'h0) $display("FAIL bypass_z_r1 got %h want 00000000", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r2 !== 32'h0) $display("FAIL bypass_z_r2 got %h want 00000000", bus.data_r2);
        else pass_cnt++;
        // Write to r7 while reading r9/r3: no bypass onto unrelated addresses.
        bus.addr_w  = 5'd7;
        bus.data_w  = 32'hA5A5A5A5;
        bus.addr_r1 = 5'd9;
        bus.addr_r2 = 5'd3;
        tick();
        bus.write = 1'b0;
        bus.read  = 1'b0;
        total_cnt++;
        if (bus.data_r1 !== 32'h5555FFFF) $display("FAIL stored_r9 got %h want 5555ffff", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r2 !== 32'hFFFFFFFF) $display("FAIL nobyp_r3 got %h want ffffffff", bus.data_r2);
        else pass_cnt++;
        rd(5'd7, 5'd7);
        total_cnt++;
        if (bus.data_r2 !== 32'hA5A5A5A5) $display("FAIL stored_r7 got %h want a5a5a5a5", bus.data_r2);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1 [4];
        logic [31:0] exp2 [4];
        exp1[0] = 32'h11; exp1[1] = 32'h22; exp1[2] = 32'h33; exp1[3] = 32'h44;
        exp2[0] = 32'h44; exp2[1] = 32'h33; exp2[2] = 32'h22; exp2[3] = 32'h11;
        wr(5'd1, 32'h11);
        wr(5'd2, 32'h22);
        wr(5'd3, 32'h33);
        wr(5'd4, 32'h44);
        bus.read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.addr_r1 = 5'(i + 1);
            bus.addr_r2 = 5'(4 - i);
            tick();
            total_cnt++;
            if (bus.valid !== 1'b1) $display("FAIL stream_valid[%0d] got %h want 1", i, bus.valid);
            else pass_cnt++;
            total_cnt++;
            if (bus.data_r1 !== exp1[i]) $display("FAIL stream_r1[%0d] got %h want %h", i, bus.data_r1, exp1[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus.data_r2 !== exp2[i]) $display("FAIL stream_r2[%0d] got %h want %h", i, bus.data_r2, exp2[i]);
            else pass_cnt++;
        end
        bus.read = 1'b0;
        tick();
        total_cnt++;
        if (bus.valid !== 1'b0) $display("FAIL stream_end_valid got %h want 0", bus.valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.read    = 1'b1;
        bus.addr_r1 = 5'd1;
        bus.addr_r2 = 5'd2;
        tick();
        reset = 1'b1;
        tick();
        total_cnt++;
        if (bus.valid !== 1'b0) $display("FAIL mid_valid got %h want 0", bus.valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r1 !== 32'h0) $display("FAIL mid_r1 got %h want 00000000", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_r2 !== 32'h0) $display("FAIL mid_r2 got %h want 00000000", bus.data_r2);
        else pass_cnt++;
        reset    = 1'b0;
        bus.read = 1'b0;
        tick();
        total_cnt++;
        if (bus.valid !== 1'b0) $display("FAIL post_valid got %h want 0", bus.valid);
        else pass_cnt++;
        rd(5'd1, 5'd4);
        total_cnt++;
        if (bus.data_r1 !== 32'h0) $display("FAIL post_r1 got %h want 00000000", bus.data_r1);
        else pass_cnt++;
        total_cnt++;
        if (bus.valid !== 1'b1) $display("FAIL post_rd_valid got %h want 1", bus.valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_zero();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_reg_file_rd

// File: doc/reg_file_rd.md
Name: reg_file_rd

Overview:
- 32-entry x 32-bit register file with one synchronous write port and two registered read ports.
- It is the read-side consumer of the per-register storage elements. The datapath fetches operands from it, with a 1-cycle read latency and a VALID qualifier.
- Entry 0 is hardwired to zero.
- It sits between instruction decode (register addresses) and the ALU operand muxes.

Parameters:
- DATA_W, 32, width of each entry and of all data ports
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- READ  in  1  read request; both read addresses are sampled on this edge
- ADDR_R1  in  ADDR_W  read port 1 address
- ADDR_R2  in  ADDR_W  read port 2 address
- WRITE  in  1  write enable
- ADDR_W  in  ADDR_W  write address
- DATA_W  in  DATA_W  write data
- DATA_R1  out  DATA_W  read port 1 data, registered
- DATA_R2  out  DATA_W  read port 2 data, registered
- VALID  out  1  high for exactly one cycle after each accepted READ

Behaviour:
- Reset:
  - RESET=1 at a rising edge clears all entries, DATA_R1, DATA_R2 and VALID to 0.
  - READ and WRITE are ignored in that cycle.
  - RESET has priority over everything.
  - Deasserting mid-operation resumes normal operation the next cycle; there is no pending read.
- Write:
  - WRITE=1 at an edge stores DATA_W into entry ADDR_W.
  - With ZERO_REG=1 and ADDR_W=0 the write is dropped.
- Read:
  - READ=1 at edge N loads DATA_R1 = entry[ADDR_R1] and DATA_R2 = entry[ADDR_R2], and sets VALID=1.
  - Data and VALID are visible after edge N; latency is 1 cycle.
- Hold:
  - READ=0 at an edge sets VALID=0.
  - DATA_R1/DATA_R2 hold their last value; they are not cleared.
- Back-to-back reads: READ held high produces a new result every cycle with VALID continuously high. No bubbles; no backpressure.
- Simultaneous read/write to the same address in the same edge: write-through bypass. The read port returns DATA_W (new value), except when ADDR_W=0 and ZERO_REG=1, where it returns 0.
- Both ports addressing the same entry return identical data.
- Zero register: with ZERO_REG=1, a read of address 0 always returns 0, whatever the write history.
- Unknown (x) DATA_W written with WRITE=1 is stored as-is; no sanitising.
- Address wrap does not apply: all 2**ADDR_W addresses are valid; there is no out-of-range case.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults
  - REG_DEPTH = 2**ADDR_W
  - the ZERO_ADDR constant (0)
- One natural sub-module: reg32_sync, a DATA_W-bit load-enabled register with synchronous active-high reset.
  - It is instantiated REG_DEPTH times, with LOAD = WRITE & (ADDR_W==i).
  - Read muxing, bypass and output registers live in reg_file_rd.

Test Plan:
- Reset:
  - Write 0xDEADBEEF to entry 5.
  - Assert RESET one cycle, then READ ADDR_R1=5, ADDR_R2=5.
  - Required: DATA_R1=DATA_R2=0x00000000, VALID=1 one cycle after READ.
- Basic write/read:
  - Write 0xFFFFFFFF to r3 and 0x12345678 to r7.
  - READ r3,r7.
  - Required: next cycle DATA_R1=0xFFFFFFFF, DATA_R2=0x12345678, VALID=1. With READ low the following cycle: VALID=0, data held.
- Zero register (ZERO_REG=1):
  - Write 0xFFFFFFFF to r0, then READ r0,r0.
  - Required: DATA_R1=DATA_R2=0, VALID=1.
- Bypass:
  - r9=0x0000AAAA, then in the same cycle WRITE r9=0x5555FFFF and READ r9,r9.
  - Required: next cycle both ports read 0x5555FFFF.
  - Same cycle with ADDR_W=0: both ports read 0.
- Streaming:
  - READ held high 4 cycles with ADDR_R1 = 1,2,3,4 (preloaded 0x11,0x22,0x33,0x44).
  - Required: VALID high 4 consecutive cycles; DATA_R1 = 0x11,0x22,0x33,0x44 in order.
- Reset mid-stream:
  - RESET asserted during a READ=1 cycle.
  - Required: next cycle VALID=0 and data 0.
  - After RESET drops with READ=0: VALID stays 0.
